// File: rtl/iter_divider.sv
// Iterative 32-bit divider, restoring radix-2, one quotient bit per clock.
// Ports: clk/rst_n; s_axis_dividend_*, s_axis_divisor_* operand slots;
//        m_axis_dout_* result {quotient[63:32], remainder[31:0]}.
module iter_divider #(
  parameter int SIGNED = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        s_axis_dividend_tvalid,
  output logic        s_axis_dividend_tready,
  input  logic [31:0] s_axis_dividend_tdata,
  input  logic        s_axis_divisor_tvalid,
  output logic        s_axis_divisor_tready,
  input  logic [31:0] s_axis_divisor_tdata,
  output logic        m_axis_dout_tvalid,
  input  logic        m_axis_dout_tready,
  output logic [63:0] m_axis_dout_tdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  logic        r_dvd_full;
  logic        r_dvs_full;
  logic [31:0] r_dvd;
  logic [31:0] r_dvs;
  logic [31:0] r_rem;
  logic [31:0] r_quo;
  logic [31:0] r_den;
  logic [4:0]  r_cnt;
  logic        r_neg_q;
  logic        r_neg_r;
  logic        r_tvalid;
  logic [63:0] r_tdata;

  logic        w_idle;
  logic        w_dvd_hs;
  logic        w_dvs_hs;
  logic        w_both;
  logic        w_sgn;
  logic        w_dvd_neg;
  logic        w_dvs_neg;
  logic [31:0] w_dvd_mag;
  logic [31:0] w_dvs_mag;
  logic        w_div0;
  logic        w_ovf;
  logic        w_special;
  logic [32:0] w_rem_sh;
  logic [32:0] w_diff;
  logic        w_ge;
  logic [31:0] w_rem_nx;
  logic [31:0] w_quo_nx;
  logic        w_last;
  logic [31:0] w_q_fin;
  logic [31:0] w_r_fin;

  assign w_idle = (r_state == IDLE);
  assign s_axis_dividend_tready = w_idle & ~r_dvd_full;
  assign s_axis_divisor_tready  = w_idle & ~r_dvs_full;
  assign w_dvd_hs = s_axis_dividend_tvalid & s_axis_dividend_tready;
  assign w_dvs_hs = s_axis_divisor_tvalid & s_axis_divisor_tready;
  assign w_both   = r_dvd_full & r_dvs_full;

  assign w_sgn     = (SIGNED != 0);
  assign w_dvd_neg = w_sgn & r_dvd[31];
  assign w_dvs_neg = w_sgn & r_dvs[31];
  assign w_dvd_mag = w_dvd_neg ? (32'd0 - r_dvd) : r_dvd;
  assign w_dvs_mag = w_dvs_neg ? (32'd0 - r_dvs) : r_dvs;

  // Cases the iteration cannot produce: divide by zero, and the one
  // signed quotient (-2^31 / -1) that does not fit in 32 bits.
  assign w_div0 = (r_dvs == 32'd0);
  assign w_ovf  = w_sgn & (r_dvd == 32'h8000_0000)
                & (r_dvs == 32'hFFFF_FFFF);
  assign w_special = w_div0 | w_ovf;

  // Quotient register doubles as the dividend shift register.
  assign w_rem_sh = {r_rem, r_quo[31]};
  assign w_diff   = w_rem_sh - {1'b0, r_den};
  assign w_ge     = ~w_diff[32];
  assign w_rem_nx = w_ge ? w_diff[31:0] : w_rem_sh[31:0];
  assign w_quo_nx = {r_quo[30:0], w_ge};
  assign w_last   = (r_cnt == 5'd31);

  assign w_q_fin = r_neg_q ? (32'd0 - w_quo_nx) : w_quo_nx;
  assign w_r_fin = r_neg_r ? (32'd0 - w_rem_nx) : w_rem_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_both) begin
          w_next = w_special ? DONE : CALC;
        end
      end
      CALC: begin
        if (w_last) begin
          w_next = DONE;
        end
      end
      DONE: begin
        if (m_axis_dout_tready) begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dvd_full <= 1'b0;
      r_dvs_full <= 1'b0;
      r_dvd      <= '0;
      r_dvs      <= '0;
      r_rem      <= '0;
      r_quo      <= '0;
      r_den      <= '0;
      r_cnt      <= '0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_tvalid   <= 1'b0;
      r_tdata    <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_dvd_hs) begin
            r_dvd      <= s_axis_dividend_tdata;
            r_dvd_full <= 1'b1;
          end
          if (w_dvs_hs) begin
            r_dvs      <= s_axis_divisor_tdata;
            r_dvs_full <= 1'b1;
          end
          if (w_both) begin
            r_cnt   <= '0;
            r_rem   <= '0;
            r_quo   <= w_dvd_mag;
            r_den   <= w_dvs_mag;
            r_neg_q <= w_dvd_neg ^ w_dvs_neg;
            r_neg_r <= w_dvd_neg;
            if (w_special) begin
              r_tvalid <= 1'b1;
              r_tdata  <= w_div0 ? {32'hFFFF_FFFF, r_dvd}
                                 : {32'h8000_0000, 32'd0};
            end
          end
        end
        CALC: begin
          r_rem <= w_rem_nx;
          r_quo <= w_quo_nx;
          r_cnt <= r_cnt + 5'd1;
          if (w_last) begin
            r_tvalid <= 1'b1;
            r_tdata  <= {w_q_fin, w_r_fin};
          end
        end
        DONE: begin
          if (m_axis_dout_tready) begin
            r_tvalid   <= 1'b0;
            r_tdata    <= '0;
            r_dvd_full <= 1'b0;
            r_dvs_full <= 1'b0;
          end
        end
        default: begin
          r_tvalid <= 1'b0;
          r_tdata  <= '0;
        end
      endcase
    end
  end

  assign m_axis_dout_tvalid = r_tvalid;
  assign m_axis_dout_tdata  = r_tdata;

endmodule

// File: tb/tb_iter_divider.sv
// Scoreboard bench for iter_divider, one unsigned and one signed instance.
// Expected results come from a behavioural division model.
module tb_iter_divider;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        dvd_v [2];
  logic        dvd_r [2];
  logic [31:0] dvd_d [2];
  logic        dvs_v [2];
  logic        dvs_r [2];
  logic [31:0] dvs_d [2];
  logic        o_v   [2];
  logic        o_r   [2];
  logic [63:0] o_d   [2];

  int n_vec = 0;
  int n_err = 0;
  logic [63:0] sb[$];

  iter_divider #(.SIGNED(0)) u_div_u (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .s_axis_dividend_tvalid (dvd_v[0]),
    .s_axis_dividend_tready (dvd_r[0]),
    .s_axis_dividend_tdata  (dvd_d[0]),
    .s_axis_divisor_tvalid  (dvs_v[0]),
    .s_axis_divisor_tready  (dvs_r[0]),
    .s_axis_divisor_tdata   (dvs_d[0]),
    .m_axis_dout_tvalid     (o_v[0]),
    .m_axis_dout_tready     (o_r[0]),
    .m_axis_dout_tdata      (o_d[0])
  );

  iter_divider #(.SIGNED(1)) u_div_s (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .s_axis_dividend_tvalid (dvd_v[1]),
    .s_axis_dividend_tready (dvd_r[1]),
    .s_axis_dividend_tdata  (dvd_d[1]),
    .s_axis_divisor_tvalid  (dvs_v[1]),
    .s_axis_divisor_tready  (dvs_r[1]),
    .s_axis_divisor_tdata   (dvs_d[1]),
    .m_axis_dout_tvalid     (o_v[1]),
    .m_axis_dout_tready     (o_r[1]),
    .m_axis_dout_tdata      (o_d[1])
  );

  task automatic check(string tag, logic [64:0] got,
                       logic [64:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic bit is_spec(int m, logic [31:0] a,
                                 logic [31:0] b);
    return (b == 32'd0) || (m == 1 && a == 32'h8000_0000
                            && b == 32'hFFFF_FFFF);
  endfunction

  function automatic logic [63:0] model(int m, logic [31:0] a,
                                        logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sd;
    logic [31:0] q;
    logic [31:0] r;
    sa = a;
    sd = b;
    if (b == 32'd0) return {32'hFFFF_FFFF, a};
    if (m == 1) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
        return {32'h8000_0000, 32'd0};
      q = sa / sd;
      r = sa % sd;
    end else begin
      q = a / b;
      r = a % b;
    end
    return {q, r};
  endfunction

  function automatic logic [31:0] rnd();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic send(int m, logic [31:0] a, logic [31:0] b,
                      int stag);
    @(negedge clk);
    check("rdy_idle", 65'({dvd_r[m], dvs_r[m]}), 65'(2'b11));
    dvd_v[m] = 1'b1;
    dvd_d[m] = a;
    if (stag == 0) begin
      dvs_v[m] = 1'b1;
      dvs_d[m] = b;
    end
    @(posedge clk);
    #1;
    dvd_v[m] = 1'b0;
    if (stag > 0) begin
      check("rdy_split", 65'({dvd_r[m], dvs_r[m]}), 65'(2'b01));
      repeat (stag - 1) @(posedge clk);
      @(negedge clk);
      dvs_v[m] = 1'b1;
      dvs_d[m] = b;
      @(posedge clk);
      #1;
    end
    dvs_v[m] = 1'b0;
    sb.push_back(model(m, a, b));
  endtask

  task automatic recv(int m, int lat_exp, int bp, bit nxt,
                      logic [31:0] na, logic [31:0] nb);
    logic [63:0] exp;
    int lat;
    lat = 0;
    o_r[m] = (bp == 0);
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!o_v[m] && lat < 40);
    check("latency", 65'(lat), 65'(lat_exp));
    exp = (sb.size() > 0) ? sb.pop_front() : 64'd0;
    check("data", 65'(o_d[m]), 65'(exp));
    if (nxt) begin
      @(negedge clk);
      dvd_v[m] = 1'b1;
      dvd_d[m] = na;
      dvs_v[m] = 1'b1;
      dvs_d[m] = nb;
    end
    for (int i = 0; i < bp; i++) begin
      @(posedge clk);
      #1;
      check("hold", {o_v[m], o_d[m]}, {1'b1, exp});
      check("rdy_busy", 65'({dvd_r[m], dvs_r[m]}), 65'(2'b00));
    end
    o_r[m] = 1'b1;
    @(posedge clk);
    #1;
    check("drain", {o_v[m], o_d[m]}, 65'd0);
    if (nxt) begin
      check("rdy_reent", 65'({dvd_r[m], dvs_r[m]}), 65'(2'b11));
      @(posedge clk);
      #1;
      dvd_v[m] = 1'b0;
      dvs_v[m] = 1'b0;
      check("rdy_cap", 65'({dvd_r[m], dvs_r[m]}), 65'(2'b00));
      sb.push_back(model(m, na, nb));
    end
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    for (int m = 0; m < 2; m++) begin
      dvd_v[m] = 1'b0;
      dvd_d[m] = '0;
      dvs_v[m] = 1'b0;
      dvs_d[m] = '0;
      o_r[m]   = 1'b1;
    end
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int m = 0; m < 2; m++) begin
      check("rst_out", {o_v[m], o_d[m]}, 65'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    for (int m = 0; m < 2; m++) begin
      check("rst_rdy", 65'({dvd_r[m], dvs_r[m]}), 65'(2'b11));
    end

    send(0, 32'd100, 32'd7, 0);
    recv(0, 33, 0, 0, 0, 0);
    send(1, 32'hFFFF_FFF9, 32'd2, 3);
    recv(1, 33, 0, 0, 0, 0);
    send(0, 32'h1234_5678, 32'd0, 0);
    recv(0, 1, 0, 0, 0, 0);
    send(1, 32'h1234_5678, 32'd0, 0);
    recv(1, 1, 0, 0, 0, 0);
    send(1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    recv(1, 1, 0, 0, 0, 0);
    send(0, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    recv(0, 33, 0, 0, 0, 0);

    send(0, 32'd100, 32'd7, 0);
    recv(0, 33, 10, 1, 32'd200, 32'd9);
    recv(0, 33, 0, 0, 0, 0);

    send(1, 32'd100, 32'd7, 0);
    repeat (16) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_mid", {o_v[1], o_d[1]}, 65'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_rel", 65'({dvd_r[1], dvs_r[1]}), 65'(2'b11));
    send(1, 32'd9, 32'd3, 0);
    recv(1, 33, 0, 0, 0, 0);

    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < 500; i++) begin
        a = rnd();
        b = rnd();
        send(m, a, b, $urandom_range(0, 3));
        recv(m, is_spec(m, a, b) ? 1 : 33,
             $urandom_range(0, 3), 0, 0, 0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
